// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the RV32I instruction encoder/loader.
package instr_encoder_pkg;

  // Immediate format selector, matching the immediate extender's ImmSrc.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_R = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RANGE    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  // True when v is representable as a signed value whose sign bit is v[msb].
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = 32'($signed(v) >>> msb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word packer with immediate range and format checks.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok,
  output logic        fmt_ok
);

  // Scatter the immediate into its format-specific bit positions.
  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    fmt_ok   = 1'b1;
    unique case (imm_src)
      IMM_I: begin
        word     = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = fits_signed(imm, 11);
      end
      IMM_S: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok = fits_signed(imm, 11);
      end
      IMM_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok = fits_signed(imm, 12) && !imm[0];
      end
      IMM_J: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_ok = fits_signed(imm, 20) && !imm[0];
      end
      IMM_U: begin
        word     = {imm[31:12], rd, opcode};
        range_ok = (imm[11:0] == 12'h000);
      end
      IMM_R: begin
        word     = {funct7, rs2, rs1, funct3, rd, opcode};
        range_ok = 1'b1;
      end
      default: fmt_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: accepts field beats, packs them and writes imem sequentially.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ImmSrc,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   count
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [31:0]       packed_word;
  logic              range_ok, fmt_ok;
  logic              accept;
  logic              overflow;
  logic [ADDR_W-1:0] tgt_addr;

  instr_pack u_pack (
    .imm_src  (ImmSrc),
    .opcode   (opcode),
    .rd       (rd),
    .funct3   (funct3),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct7   (funct7),
    .imm      (imm),
    .word     (packed_word),
    .range_ok (range_ok),
    .fmt_ok   (fmt_ok)
  );

  assign in_ready = (state_q == StLoad) && !start;
  assign accept   = in_valid && in_ready;
  // count saturates at 2^ADDR_W, so the top bit alone flags a full memory.
  assign overflow = count_q[ADDR_W];
  assign tgt_addr = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];

  // Next-state: start restarts the load, otherwise check and pack an accepted beat.
  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = (state_q == StDone) && !start;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    count_d    = count_q;
    if (start) begin
      state_d    = StLoad;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      err_addr_d = '0;
      count_d    = '0;
    end else if (accept) begin
      if (!fmt_ok || overflow || !range_ok) begin
        state_d    = StErr;
        err_d      = 1'b1;
        err_addr_d = tgt_addr;
        if (!fmt_ok)       err_code_d = ERR_ILLEGAL;
        else if (overflow) err_code_d = ERR_OVERFLOW;
        else               err_code_d = ERR_RANGE;
      end else begin
        we_d    = 1'b1;
        addr_d  = tgt_addr;
        wdata_d = packed_word;
        count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
        if (last) state_d = StDone;
      end
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
      count_q    <= count_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_addr   = err_addr_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a full-size and a 4-word instance share one stimulus stream.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, last;
  logic [2:0]  imm_src;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic        in_ready_a, we_a, done_a, err_a;
  logic [7:0]  addr_a, err_addr_a;
  logic [31:0] wdata_a;
  logic [1:0]  code_a;
  logic [8:0]  count_a;

  logic        in_ready_b, we_b, done_b, err_b;
  logic [1:0]  addr_b, err_addr_b;
  logic [31:0] wdata_b;
  logic [1:0]  code_b;
  logic [2:0]  count_b;

  int checks   = 0;
  int failures = 0;
  int model_cnt = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } wr_t;
  wr_t q_a[$];
  wr_t q_b[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .ImmSrc(imm_src), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .last(last), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .done(done_a), .err(err_a), .err_code(code_a),
    .err_addr(err_addr_a), .count(count_a)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .ImmSrc(imm_src), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .last(last), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .done(done_b), .err(err_b), .err_code(code_b),
    .err_addr(err_addr_b), .count(count_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (q_a.size() == 0) check("unexpected_write_a", {63'd0, we_a}, 64'd0);
      else begin
        wr_t e;
        e = q_a.pop_front();
        check("wr_addr_a", {56'd0, addr_a}, {56'd0, e.addr});
        check("wr_data_a", {32'd0, wdata_a}, {32'd0, e.word});
      end
    end
    if (we_b === 1'b1) begin
      if (q_b.size() == 0) check("unexpected_write_b", {63'd0, we_b}, 64'd0);
      else begin
        wr_t e;
        e = q_b.pop_front();
        check("wr_addr_b", {62'd0, addr_b}, {56'd0, e.addr});
        check("wr_data_b", {32'd0, wdata_b}, {32'd0, e.word});
      end
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog timeout");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_cnt = 0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd_v,
                      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] im, input logic lst, input logic good,
                      input logic [31:0] exp_word);
    int n;
    wr_t e;
    imm_src = src; opcode = op; rd = rd_v; funct3 = f3; rs1 = r1; rs2 = r2;
    funct7 = 7'h00; imm = im; last = lst; in_valid = 1'b1;
    if (good) begin
      e.addr = 8'(model_cnt);
      e.word = exp_word;
      q_a.push_back(e);
      if (model_cnt < 4) q_b.push_back(e);
      model_cnt++;
    end
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("ready_timeout", {63'd0, in_ready_a}, 64'd1);
    @(posedge clk); #1;
  endtask

  // addi rd, x0, v
  task automatic send_addi(input logic [4:0] r, input logic [11:0] v, input logic good);
    send(IMM_I, OPC_OP_IMM, r, 3'd0, 5'd0, 5'd0, {{20{v[11]}}, v}, 1'b0, good,
         {v, 5'd0, 3'd0, r, 7'h13});
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    imm_src = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0;
    funct7 = '0; imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", {63'd0, we_a}, 64'd0);
    check("rst_ready", {63'd0, in_ready_a}, 64'd0);
    check("rst_count", {55'd0, count_a}, 64'd0);
    check("rst_err", {61'd0, err_a, code_a}, 64'd0);
    check("rst_done", {63'd0, done_a}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single I-type beat
    do_start();
    send(IMM_I, OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0050_0093);
    idle();
    @(negedge clk);
    check("i_count", {55'd0, count_a}, 64'd1);
    drain();

    // Back-to-back S, B, then boundary immediates (B instance overflows on the 5th)
    do_start();
    send(IMM_S, OPC_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020_A423);
    send(IMM_B, OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, -32'sd4, 1'b0, 1'b1, 32'hFE00_0EE3);
    send(IMM_I, OPC_OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, -32'sd2048, 1'b0, 1'b1, 32'h8000_0013);
    send(IMM_B, OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 32'd4094, 1'b0, 1'b1, 32'h7E00_0FE3);
    send(IMM_J, OPC_JAL, 5'd0, 3'd0, 5'd0, 5'd0, -32'sd1048576, 1'b0, 1'b1, 32'h8000_006F);
    idle();
    @(negedge clk);
    check("bnd_count_a", {55'd0, count_a}, 64'd5);
    check("bnd_err_a", {63'd0, err_a}, 64'd0);
    check("bnd_code_b", {62'd0, code_b}, 64'(ERR_OVERFLOW));
    drain();

    // J then U with last; done follows the write by one cycle
    do_start();
    send(IMM_J, OPC_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b1, 32'h0010_00EF);
    send(IMM_U, OPC_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b1, 32'h1234_52B7);
    idle();
    @(negedge clk);
    check("done_early", {63'd0, done_a}, 64'd0);
    check("done_ready", {63'd0, in_ready_a}, 64'd0);
    @(negedge clk);
    check("done_a", {63'd0, done_a}, 64'd1);
    check("done_b", {63'd0, done_b}, 64'd1);
    check("done_count", {55'd0, count_a}, 64'd2);
    drain();

    // Range error after two good words, then start clears it
    do_start();
    check("start_clr_done", {63'd0, done_a}, 64'd0);
    send_addi(5'd1, 12'd1, 1'b1);
    send_addi(5'd2, 12'd2, 1'b1);
    send(IMM_I, OPC_OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    check("rng_err", {63'd0, err_a}, 64'd1);
    check("rng_code", {62'd0, code_a}, 64'(ERR_RANGE));
    check("rng_addr", {56'd0, err_addr_a}, 64'd2);
    check("rng_ready", {63'd0, in_ready_a}, 64'd0);
    check("rng_count", {55'd0, count_a}, 64'd2);
    drain();
    do_start();
    @(negedge clk);
    check("clr_err", {61'd0, err_a, code_a}, 64'd0);
    check("clr_count", {55'd0, count_a}, 64'd0);
    check("clr_ready", {63'd0, in_ready_a}, 64'd1);
    @(posedge clk); #1;

    // Odd branch offset and U with low bits set are range errors
    send(IMM_B, OPC_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 32'd6 + 32'd1, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    check("b_odd_code", {62'd0, code_a}, 64'(ERR_RANGE));
    @(posedge clk); #1;
    do_start();
    send(IMM_U, OPC_LUI, 5'd1, 3'd0, 5'd0, 5'd0, 32'h1234_5001, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    check("u_low_code", {62'd0, code_a}, 64'(ERR_RANGE));
    drain();

    // Overflow on the 4-word instance
    do_start();
    for (int i = 0; i < 5; i++) send_addi(5'(i + 1), 12'(i + 10), 1'b1);
    idle();
    @(negedge clk);
    check("ovf_err_b", {63'd0, err_b}, 64'd1);
    check("ovf_code_b", {62'd0, code_b}, 64'(ERR_OVERFLOW));
    check("ovf_addr_b", {62'd0, err_addr_b}, 64'd0);
    check("ovf_count_b", {61'd0, count_b}, 64'd4);
    check("ovf_count_a", {55'd0, count_a}, 64'd5);
    check("ovf_err_a", {63'd0, err_a}, 64'd0);
    drain();

    // Illegal ImmSrc outranks overflow
    do_start();
    for (int i = 0; i < 4; i++) send_addi(5'(i + 1), 12'(i + 20), 1'b1);
    send(3'b110, OPC_OP, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle();
    @(negedge clk);
    check("ill_code_a", {62'd0, code_a}, 64'(ERR_ILLEGAL));
    check("ill_addr_a", {56'd0, err_addr_a}, 64'd4);
    check("ill_code_b", {62'd0, code_b}, 64'(ERR_ILLEGAL));
    drain();

    // Reset mid-stream with start and a beat; coinciding beats never get written
    do_start();
    send_addi(5'd3, 12'd3, 1'b1);
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    imm = 32'd7; rd = 5'd7;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_we", {63'd0, we_a}, 64'd0);
    check("mid_rst_addr", {56'd0, addr_a}, 64'd0);
    check("mid_rst_wdata", {32'd0, wdata_a}, 64'd0);
    check("mid_rst_count", {55'd0, count_a}, 64'd0);
    check("mid_rst_ready", {63'd0, in_ready_a}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    model_cnt = 0;
    drain();
    check("post_count", {55'd0, count_a}, 64'd0);
    check("post_ready", {63'd0, in_ready_a}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder and loader. It is the inverse of the immediate extender. It accepts decoded fields (format, registers, functs, opcode, 32-bit immediate) over a valid/ready handshake. It range-checks the immediate, packs a 32-bit instruction word and writes it sequentially into instruction memory through a registered write port. Used by the test harness and boot loader to fill imem before the core leaves reset.

Parameters:
ADDR_W, 8, imem word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous, active-high
start  input  1  pulse: clear counter/flags, enter LOAD
in_valid  input  1  field beat valid
in_ready  output  1  encoder can accept beat
ImmSrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 110/111 illegal
opcode  input  7  instr[6:0]
rd  input  5  destination register
funct3  input  3  funct3 field
rs1  input  5  source 1
rs2  input  5  source 2
funct7  input  7  R-type only
imm  input  32  signed byte-offset / value
last  input  1  final beat of program
imem_we  output  1  write strobe, one cycle per word
imem_addr  output  ADDR_W  word address
imem_wdata  output  32  encoded instruction
done  output  1  program loaded, held until start/reset
err  output  1  sticky error
err_code  output  2  01 range, 10 illegal ImmSrc, 11 overflow
err_addr  output  ADDR_W  address the faulting beat targeted
count  output  ADDR_W+1  words written since start

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (ports clk, reset). Reset forces IDLE and drives every output to 0.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE -> LOAD on start.
  - LOAD -> DONE on an accepted beat with last=1 and no error.
  - LOAD -> ERR on an accepted beat that fails a check.
  - DONE/ERR -> LOAD on start.
  - start in LOAD restarts the load: counter = 0, next address = BASE_ADDR.
- start always clears done, err, err_code, err_addr and count.
- in_ready = 1 only in LOAD with start low. A beat presented in the same cycle as start is ignored.
- Accept = in_valid && in_ready.
- Latency: an accepted legal beat produces imem_we=1 on the next cycle, with imem_addr = BASE_ADDR + count and the packed word. count increments in that same cycle. imem_we is 0 otherwise. Back-to-back beats give one write per cycle (full throughput).
- Packing, bit 31 down to bit 0:
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - U: imm[31:12], rd, opcode
  - R: funct7, rs2, rs1, funct3, rd, opcode; imm ignored
- Range checks (code 01):
  - I/S: -2048 <= imm <= 2047
  - B: -4096 <= imm <= 4094 and imm[0] = 0
  - J: -1048576 <= imm <= 1048574 and imm[0] = 0
  - U: imm[11:0] = 0
- Illegal ImmSrc: code 10.
- Overflow: a beat accepted when count = 2^ADDR_W gives code 11. The counter never wraps.
- Error priority: illegal ImmSrc > overflow > range.
- On error: no write. err=1, err_code and err_addr latched the cycle after accept. in_ready drops in that same cycle.
- Round-trip invariant: the immediate extender applied to imem_wdata with the same ImmSrc returns imm for every legal I/S/B/J/U beat.

Decomposition:
- Shared package: ImmSrc encodings, err_code constants, state enum, RV32I opcode constants.
- One natural sub-module: instr_pack, purely combinational. It takes the fields and ImmSrc and outputs the packed word plus range_ok and fmt_ok.
- The top module keeps the FSM, counter, output register and error latches.

Test Plan:
- ImmSrc=000, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle imem_we=1, addr=0, wdata=0x00500093, count=1.
- ImmSrc=001, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 → 0x0020A423. Then ImmSrc=010, opcode 0x63, rs1=rs2=0, imm=-4 → 0xFE000EE3. Back-to-back beats, addrs 0 and 1.
- ImmSrc=011, opcode 0x6F, rd=1, imm=2048 → 0x001000EF. Then ImmSrc=100, opcode 0x37, rd=5, imm=0x12345000 with last=1 → 0x123452B7, and done=1 the cycle after the write.
- After 2 good words, I-type imm=2048 -> no write, err=1, err_code=01, err_addr=2, in_ready=0. Then start -> err=0, count=0, in_ready=1.
- ADDR_W=2, 5 legal beats -> 4 writes to addrs 0-3, 5th beat gives err_code=11, err_addr=0, count=4.
- Assert reset mid-stream and start together with in_valid -> all outputs 0 next cycle, and the beat coinciding with start is never written.
